stopwatch_digit_source: RTL and testbench

//  Upstream producer for the 4-digit seven-segment display controller: a centisecond

---
 rtl/stopwatch_digit_source_pkg.sv | 41 ++++
 rtl/stopwatch_digit_source_if.sv | 13 +
 rtl/stopwatch_digit_source_debounce.sv | 49 ++++
 rtl/stopwatch_digit_source.sv | 152 +++++++++++++++
 tb/tb_stopwatch_digit_source.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_digit_source_pkg.sv
// Shared types and constants for the centisecond stopwatch digit source.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_e;

    localparam logic [3:0]  BCD_MAX    = 4'd9;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 4;

    typedef logic [NUM_DIGITS*DIGIT_W-1:0] bcd_count_t;

    typedef struct packed {
        logic       wrap;
        bcd_count_t value;
    } bcd_step_t;

    // Ripple-carry BCD increment; any digit at or above BCD_MAX wraps to zero.
    function automatic bcd_step_t bcd_inc(input bcd_count_t v);
        bcd_step_t r;
        logic      carry;
        r.value = v;
        carry   = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (v[i*DIGIT_W +: DIGIT_W] >= BCD_MAX) begin
                    r.value[i*DIGIT_W +: DIGIT_W] = '0;
                end else begin
                    r.value[i*DIGIT_W +: DIGIT_W] = v[i*DIGIT_W +: DIGIT_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        r.wrap = carry;
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_digit_source_if.sv
// Display-side bus from the stopwatch to the seven-segment controller.
interface stopwatch_digit_source_if;
    import stopwatch_pkg::*;

    bcd_count_t digits;
    logic       tick;
    logic       rollover;
    logic       running;

    modport master (output digits, output tick, output rollover, output running);
    modport slave  (input  digits, input  tick, input  rollover, input  running);

endinterface

// File: rtl/stopwatch_digit_source_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, press pulse on debounced rise.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic             level;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
        end
    end

    // cnt tracks how many consecutive samples have disagreed with the current level.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync_b;
                press <= sync_b;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_digit_source.sv
// Centisecond stopwatch (SS.cc) feeding the 4-digit display controller.
// Optional lap hold on btn_lap when STOPWATCH_LAP_HOLD_EN is defined.
module stopwatch_digit_source
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 100_000_000,
    parameter int unsigned TICK_HZ         = 100,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     btn_start,
    input  logic                     btn_clear,
`ifdef STOPWATCH_LAP_HOLD_EN
    input  logic                     btn_lap,
`endif
    stopwatch_digit_source_if.master disp
);

    localparam int unsigned DIV   = CLK_HZ / TICK_HZ - 1;
    localparam int unsigned PRE_W = (DIV > 0) ? $clog2(DIV + 1) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV);

    logic             start_p;
    logic             clear_p;
    sw_state_e        state_q;
    sw_state_e        state_d;
    logic             zero_count;
    logic [PRE_W-1:0] presc_q;
    bcd_count_t       count_q;
    bcd_step_t        step;
    logic             tick_q;
    logic             rollover_q;
    logic             running_q;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_start),
        .press (start_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_clear),
        .press (clear_p)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == RUN);
        end
    end

    // Start wins in RUN (clear ignored there); clear wins in PAUSE and IDLE.
    always_comb begin
        state_d    = state_q;
        zero_count = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clear_p) begin
                    zero_count = 1'b1;
                end else if (start_p) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (start_p) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (clear_p) begin
                    state_d    = IDLE;
                    zero_count = 1'b1;
                end else if (start_p) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb step = bcd_inc(count_q);

    // Prescaler only advances in RUN, so PAUSE keeps the sub-tick phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            count_q    <= '0;
            tick_q     <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            tick_q     <= 1'b0;
            rollover_q <= 1'b0;
            if (zero_count) begin
                presc_q <= '0;
                count_q <= '0;
            end else if (state_q == RUN) begin
                if (presc_q == PRE_LAST) begin
                    presc_q    <= '0;
                    tick_q     <= 1'b1;
                    count_q    <= step.value;
                    rollover_q <= step.wrap;
                end else begin
                    presc_q <= presc_q + PRE_W'(1);
                end
            end
        end
    end

`ifdef STOPWATCH_LAP_HOLD_EN
    logic       lap_p;
    logic       hold_q;
    bcd_count_t held_q;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_lap),
        .press (lap_p)
    );

    always_ff @(posedge clk) begin
        if (rst || zero_count) begin
            hold_q <= 1'b0;
            held_q <= '0;
        end else if (state_q == RUN) begin
            if (start_p) begin
                hold_q <= 1'b0;
            end else if (lap_p) begin
                hold_q <= ~hold_q;
                held_q <= count_q;
            end
        end
    end

    assign disp.digits = hold_q ? held_q : count_q;
`else
    assign disp.digits = count_q;
`endif

    assign disp.tick     = tick_q;
    assign disp.rollover = rollover_q;
    assign disp.running  = running_q;

endmodule

// File: tb/tb_stopwatch_digit_source.sv
// Self-checking bench: arithmetic reference model plus directed button sequences.
// Lap-hold scenario is exercised only when STOPWATCH_LAP_HOLD_EN is defined.
module tb_stopwatch_digit_source;

    localparam int DEB     = 4;
    localparam int DIV     = 9;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;

    logic clk = 1'b0;
    logic rst;
    logic btn_start;
    logic btn_clear;
`ifdef STOPWATCH_LAP_HOLD_EN
    logic btn_lap;
`endif
    logic f_start;
    bit   f_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stopwatch_digit_source_if disp();
    stopwatch_digit_source_if fdisp();

    stopwatch_digit_source #(.CLK_HZ(1000), .TICK_HZ(100), .DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
`ifdef STOPWATCH_LAP_HOLD_EN
        .btn_lap   (btn_lap),
`endif
        .disp      (disp)
    );

    // Fast instance (tick every 2 cycles) reaches 99.99 in a practical time.
    stopwatch_digit_source #(.CLK_HZ(200), .TICK_HZ(100), .DEBOUNCE_CYCLES(1)) dut_fast (
        .clk       (clk),
        .rst       (rst),
        .btn_start (f_start),
        .btn_clear (1'b0),
`ifdef STOPWATCH_LAP_HOLD_EN
        .btn_lap   (1'b0),
`endif
        .disp      (fdisp)
    );

    function automatic logic [15:0] bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: count as an integer, buttons as a sliding window of synced samples.
    int  m_state, m_presc, m_cnt, m_held;
    bit  m_tick, m_roll, m_run, m_hold, m_valid;
    bit  m_raw [3][2];
    bit  m_win [3][DEB];
    bit  m_lvl [3];
    bit  m_prs [3];

    always @(posedge clk) begin : model
        bit raw_now [3];
        bit sp, cp, lp, syncv, all_diff;
        raw_now[0] = btn_start;
        raw_now[1] = btn_clear;
`ifdef STOPWATCH_LAP_HOLD_EN
        raw_now[2] = btn_lap;
`else
        raw_now[2] = 1'b0;
`endif
        if (rst) begin
            m_state = S_IDLE; m_presc = 0; m_cnt = 0; m_held = 0;
            m_tick = 0; m_roll = 0; m_run = 0; m_hold = 0; m_valid = 1;
            for (int b = 0; b < 3; b++) begin
                m_raw[b][0] = 0; m_raw[b][1] = 0;
                m_lvl[b] = 0; m_prs[b] = 0;
                for (int i = 0; i < DEB; i++) m_win[b][i] = 0;
            end
        end else begin
            sp = m_prs[0]; cp = m_prs[1]; lp = m_prs[2];
            m_tick = 0; m_roll = 0;
            if (m_state == S_RUN) begin
                if (sp) m_hold = 0;
                else if (lp) begin
                    if (m_hold) m_hold = 0;
                    else begin m_hold = 1; m_held = m_cnt; end
                end
                if (m_presc == DIV) begin
                    m_presc = 0; m_tick = 1; m_cnt = m_cnt + 1;
                    if (m_cnt == 10000) begin m_cnt = 0; m_roll = 1; end
                end else begin
                    m_presc = m_presc + 1;
                end
            end
            case (m_state)
                S_IDLE:  if (cp) begin m_cnt = 0; m_presc = 0; end
                         else if (sp) m_state = S_RUN;
                S_RUN:   if (sp) m_state = S_PAUSE;
                default: if (cp) begin m_state = S_IDLE; m_cnt = 0; m_presc = 0; m_hold = 0; end
                         else if (sp) m_state = S_RUN;
            endcase
            m_run = (m_state == S_RUN);
            for (int b = 0; b < 3; b++) begin
                syncv = m_raw[b][0];
                m_raw[b][0] = m_raw[b][1];
                m_raw[b][1] = raw_now[b];
                for (int i = DEB - 1; i > 0; i--) m_win[b][i] = m_win[b][i-1];
                m_win[b][0] = syncv;
                all_diff = 1;
                for (int i = 0; i < DEB; i++) if (m_win[b][i] == m_lvl[b]) all_diff = 0;
                m_prs[b] = 0;
                if (all_diff) begin
                    m_lvl[b] = !m_lvl[b];
                    m_prs[b] = m_lvl[b];
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        if (m_valid) begin
            check("digits",   disp.digits,   m_hold ? bcd(m_held) : bcd(m_cnt));
            check("tick",     disp.tick,     m_tick);
            check("rollover", disp.rollover, m_roll);
            check("running",  disp.running,  m_run);
        end
    end

    // Fast instance: RUN from the 4th edge, a tick every second edge after that.
    initial begin : fast_check
        int j, m;
        bit tk;
        f_start = 1'b0;
        f_done  = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 20 && rst; i++) @(negedge clk);
        f_start = 1'b1;
        for (int k = 1; k <= 20010; k++) begin
            @(negedge clk);
            if (k >= 4) begin
                j  = k - 4;
                m  = j / 2;
                tk = (j > 0) && (j % 2 == 0);
                check("fast_tick",     fdisp.tick,     tk);
                check("fast_digits",   fdisp.digits,   bcd(m % 10000));
                check("fast_rollover", fdisp.rollover, tk && (m % 10000 == 0));
                check("fast_running",  fdisp.running,  1);
            end else begin
                check("fast_running_pre", fdisp.running, 0);
            end
        end
        f_done = 1'b1;
    end

    initial begin : stimulus
        int i;
        rst = 1'b1; btn_start = 1'b0; btn_clear = 1'b0;
`ifdef STOPWATCH_LAP_HOLD_EN
        btn_lap = 1'b0;
`endif
        // reset held three cycles
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            check("rst_digits",  disp.digits,  16'h0000);
            check("rst_tick",    disp.tick,    0);
            check("rst_running", disp.running, 0);
        end
        rst = 1'b0;

        // short glitch on start is filtered
        btn_start = 1'b1; cyc(2); btn_start = 1'b0; cyc(12);
        check("glitch_running", disp.running, 0);

        // genuine press: RUN after 7 edges, first tick 10 edges later
        btn_start = 1'b1; cyc(6);
        check("start_pre_running", disp.running, 0);
        cyc(1);
        check("start_running", disp.running, 1);
        cyc(3); btn_start = 1'b0; cyc(6);
        check("first_tick_early", disp.tick, 0);
        check("first_digits_early", disp.digits, 16'h0000);
        cyc(1);
        check("first_tick", disp.tick, 1);
        check("first_digits", disp.digits, 16'h0001);

        // pause 5 cycles past a tick, resume: tick after the remaining 5 cycles
        for (i = 0; i < 50 && !(m_state == S_RUN && m_presc == 8); i++) cyc(1);
        check("wait_presc8", (m_presc == 8), 1);
        btn_start = 1'b1; cyc(7);
        check("pause_running", disp.running, 0);
        check("pause_digits", disp.digits, 16'h0002);
        cyc(1); btn_start = 1'b0; cyc(12);
        check("pause_frozen", disp.digits, 16'h0002);
        btn_start = 1'b1; cyc(7);
        check("resume_running", disp.running, 1);
        btn_start = 1'b0; cyc(4);
        check("resume_tick_early", disp.tick, 0);
        cyc(1);
        check("resume_tick", disp.tick, 1);
        check("resume_digits", disp.digits, 16'h0003);

        // clear in RUN ignored
        btn_clear = 1'b1; cyc(8); btn_clear = 1'b0;
        check("clear_in_run", disp.running, 1);
        cyc(10);

        // pause at 03.42, then clear
        for (i = 0; i < 5000 && !(m_cnt == 342 && m_presc == 0); i++) cyc(1);
        check("wait_342", bcd(m_cnt), 16'h0342);
        btn_start = 1'b1; cyc(7);
        check("p342_running", disp.running, 0);
        check("p342_digits", disp.digits, 16'h0342);
        btn_start = 1'b0; cyc(12);
        btn_clear = 1'b1; cyc(7);
        check("clear_digits", disp.digits, 16'h0000);
        check("clear_running", disp.running, 0);
        btn_clear = 1'b0; cyc(12);

        // start+clear together in PAUSE: clear wins
        btn_start = 1'b1; cyc(7);
        check("run2_running", disp.running, 1);
        btn_start = 1'b0; cyc(20);
        btn_start = 1'b1; cyc(7);
        check("pause2_running", disp.running, 0);
        btn_start = 1'b0; cyc(12);
        btn_start = 1'b1; btn_clear = 1'b1; cyc(7);
        check("both_pause_running", disp.running, 0);
        check("both_pause_digits", disp.digits, 16'h0000);
        btn_start = 1'b0; btn_clear = 1'b0; cyc(12);

        // start+clear together in IDLE: stays IDLE
        btn_start = 1'b1; btn_clear = 1'b1; cyc(7);
        check("both_idle_running", disp.running, 0);
        btn_start = 1'b0; btn_clear = 1'b0; cyc(12);

`ifdef STOPWATCH_LAP_HOLD_EN
        // lap hold at 00.12 for 30 cycles, release shows live 00.15
        btn_start = 1'b1; cyc(7);
        check("lap_run", disp.running, 1);
        btn_start = 1'b0;
        for (i = 0; i < 500 && !(m_cnt == 12 && m_presc == 0); i++) cyc(1);
        check("wait_12", bcd(m_cnt), 16'h0012);
        btn_lap = 1'b1; cyc(7);
        check("lap_hold", disp.digits, 16'h0012);
        btn_lap = 1'b0;
        for (i = 0; i < 100 && !(m_cnt == 15 && m_presc == 0); i++) begin
            cyc(1);
            check("lap_frozen", disp.digits, 16'h0012);
        end
        check("wait_15", bcd(m_cnt), 16'h0015);
        btn_lap = 1'b1; cyc(6);
        check("lap_still", disp.digits, 16'h0012);
        cyc(1);
        check("lap_release", disp.digits, 16'h0015);
        btn_lap = 1'b0; cyc(12);
`endif

        for (i = 0; i < 30000 && !f_done; i++) cyc(1);
        check("fast_done", f_done, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
